mem_arbiter: RTL and testbench

Single-port RAM arbiter for the pipelined CPU. Shares one synchronous-read block RAM between three requesters: the UART programmer, the MEM-stage data port and the IF-stage instruction port. Generates the stall requests the pipeline controller consumes. It sits between the IF/MEM stages and the RAM macro, so instruction and data memory can be unified into a single BRAM.

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port BRAM arbiter: UART programmer > MEM data port > IF instruction port.
// Optional IF anti-starvation counter is enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              u_req,
    input  logic [ADDR_W-1:0] u_addr,
    input  logic [DATA_W-1:0] u_wdata,
    input  logic              u_done,
    output logic              u_gnt,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall_req_if,
    output logic              stall_req_mem
);

    typedef enum logic {NORMAL = 1'b0, PROG = 1'b1} state_t;

    state_t state_reg, state_next;
    logic   owner_i_reg, owner_d_reg;
    logic   force_i;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_reg;

    // Counts consecutive NORMAL cycles where IF asked and lost; saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_reg <= '0;
        end else if (state_reg == PROG || !i_req || i_gnt) begin
            starve_reg <= '0;
        end else if (starve_reg != STARVE_LIM) begin
            starve_reg <= starve_reg + 1'b1;
        end
    end

    assign force_i = (state_reg == NORMAL) && i_req && (starve_reg == STARVE_LIM);
`else
    // Strict fixed priority: IF is never promoted above the data port.
    assign force_i = (STARVE_MAX < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= NORMAL;
            owner_i_reg <= 1'b0;
            owner_d_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_i_reg <= i_gnt;
            owner_d_reg <= d_gnt & ~d_we;
        end
    end

    always_comb begin
        state_next = state_reg;
        u_gnt      = 1'b0;
        d_gnt      = 1'b0;
        i_gnt      = 1'b0;
        case (state_reg)
            NORMAL: if (!u_done && u_req) state_next = PROG;
            PROG:   if (u_done) state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
        if (rst) begin
            u_gnt = u_req;
            if (state_reg == NORMAL && !u_req) begin
                if (force_i) begin
                    i_gnt = 1'b1;
                end else if (d_req) begin
                    d_gnt = 1'b1;
                end else begin
                    i_gnt = i_req;
                end
            end
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (u_gnt) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = u_addr;
            ram_wdata = u_wdata;
        end else if (d_gnt) begin
            ram_en    = 1'b1;
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end else if (i_gnt) begin
            ram_en   = 1'b1;
            ram_addr = i_addr;
        end
    end

    assign i_rvalid      = owner_i_reg;
    assign d_rvalid      = owner_d_reg;
    assign i_rdata       = owner_i_reg ? ram_rdata : '0;
    assign d_rdata       = owner_d_reg ? ram_rdata : '0;
    assign stall_req_if  = i_req & ~i_gnt;
    assign stall_req_mem = d_req & ~d_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural read-first synchronous RAM.
module tb_mem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req, d_req, d_we, u_req, u_done;
    logic [ADDR_W-1:0] i_addr, d_addr, u_addr;
    logic [DATA_W-1:0] d_wdata, u_wdata;
    logic              i_gnt, i_rvalid, d_gnt, d_rvalid, u_gnt;
    logic [DATA_W-1:0] i_rdata, d_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              stall_req_if, stall_req_mem;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .u_req(u_req), .u_addr(u_addr), .u_wdata(u_wdata), .u_done(u_done), .u_gnt(u_gnt),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit exp_i;
        mem[14'h010] = 32'hDEADBEEF;
        mem[14'h020] = 32'hCAFEF00D;
        mem[14'h030] = 32'h0BADF00D;
        ram_rdata = '0;
        rst = 1'b0;
        i_req = 1'b1; d_req = 1'b1; u_req = 1'b1; u_done = 1'b0; d_we = 1'b0;
        i_addr = 14'h010; d_addr = 14'h020; u_addr = 14'h000;
        d_wdata = '0; u_wdata = '0;

        // Reset held with every request active
        #3;
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_u_gnt", u_gnt, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_stall_if", stall_req_if, 1);
        chk("rst_stall_mem", stall_req_mem, 1);
        chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);

        // Release: d wins the first NORMAL cycle
        next_cycle();
        next_cycle();
        u_req = 1'b0; rst = 1'b1;
        #1;
        chk("rel_d_gnt", d_gnt, 1);
        chk("rel_i_gnt", i_gnt, 0);
        chk("rel_stall_if", stall_req_if, 1);
        next_cycle();
        i_req = 1'b0; d_req = 1'b0;
        #1;
        chk("rel_d_rvalid", d_rvalid, 1);
        chk("rel_d_rdata", d_rdata, 32'hCAFEF00D);

        // Lone IF read
        next_cycle();
        i_req = 1'b1; i_addr = 14'h010;
        #1;
        chk("if_gnt", i_gnt, 1);
        chk("if_ram_addr", ram_addr, 14'h010);
        chk("if_ram_we", ram_we, 0);
        next_cycle();
        i_req = 1'b0;
        #1;
        chk("if_rvalid", i_rvalid, 1);
        chk("if_rdata", i_rdata, 32'hDEADBEEF);
        chk("if_d_rvalid", d_rvalid, 0);
        chk("if_d_rdata", d_rdata, 0);

        // IF and MEM together, then pipelined IF read
        next_cycle();
        i_req = 1'b1; i_addr = 14'h030; d_req = 1'b1; d_addr = 14'h020; d_we = 1'b0;
        #1;
        chk("both_d_gnt", d_gnt, 1);
        chk("both_i_gnt", i_gnt, 0);
        chk("both_stall_if", stall_req_if, 1);
        chk("both_ram_addr", ram_addr, 14'h020);
        next_cycle();
        d_req = 1'b0;
        #1;
        chk("pipe_i_gnt", i_gnt, 1);
        chk("pipe_d_rvalid", d_rvalid, 1);
        chk("pipe_d_rdata", d_rdata, 32'hCAFEF00D);
        chk("pipe_i_rvalid", i_rvalid, 0);
        next_cycle();
        i_req = 1'b0;
        #1;
        chk("pipe_i_rvalid2", i_rvalid, 1);
        chk("pipe_i_rdata", i_rdata, 32'h0BADF00D);
        chk("pipe_d_rvalid2", d_rvalid, 0);

        // Data write, then read-back of the same address
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h040; d_wdata = 32'h55AA33CC;
        #1;
        chk("wr_d_gnt", d_gnt, 1);
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_wdata", ram_wdata, 32'h55AA33CC);
        next_cycle();
        d_we = 1'b0;
        #1;
        chk("wr_no_rvalid", d_rvalid, 0);
        next_cycle();
        d_req = 1'b0;
        #1;
        chk("rbk_rvalid", d_rvalid, 1);
        chk("rbk_rdata", d_rdata, 32'h55AA33CC);

        // Programmer owns the RAM
        next_cycle();
        u_req = 1'b1; u_addr = 14'h005; u_wdata = 32'h12345678; i_req = 1'b1; i_addr = 14'h005;
        #1;
        chk("prog_u_gnt", u_gnt, 1);
        chk("prog_i_gnt", i_gnt, 0);
        chk("prog_ram_we", ram_we, 1);
        chk("prog_ram_addr", ram_addr, 14'h005);
        next_cycle();
        u_req = 1'b0; d_req = 1'b1; d_we = 1'b0;
        #1;
        chk("prog_i_hold", i_gnt, 0);
        chk("prog_d_hold", d_gnt, 0);
        chk("prog_stall_mem", stall_req_mem, 1);
        chk("prog_ram_en", ram_en, 0);
        next_cycle();
        d_req = 1'b0; u_done = 1'b1;
        #1;
        chk("prog_done_i", i_gnt, 0);
        chk("prog_done_stall", stall_req_if, 1);
        next_cycle();
        u_done = 1'b0;
        #1;
        chk("post_i_gnt", i_gnt, 1);
        chk("post_ram_addr", ram_addr, 14'h005);
        next_cycle();
        i_req = 1'b0;
        #1;
        chk("post_i_rvalid", i_rvalid, 1);
        chk("post_i_rdata", i_rdata, 32'h12345678);

        // IF competing with continuous MEM reads
        next_cycle();
        i_req = 1'b1; i_addr = 14'h010; d_req = 1'b1; d_addr = 14'h020; d_we = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            #1;
`ifdef MEM_ARB_FAIRNESS_EN
            exp_i = (k % 5 == 0);
`else
            exp_i = 1'b0;
`endif
            chk($sformatf("starve_i_%0d", k), i_gnt, exp_i);
            chk($sformatf("starve_d_%0d", k), d_gnt, !exp_i);
            next_cycle();
        end
        i_req = 1'b0; d_req = 1'b0;

        // Reset asserted with a data read in flight
        next_cycle();
        d_req = 1'b1; d_addr = 14'h020;
        #1;
        chk("mid_d_gnt", d_gnt, 1);
        next_cycle();
        d_req = 1'b0; rst = 1'b0;
        #1;
        chk("mid_d_rvalid", d_rvalid, 0);
        chk("mid_d_rdata", d_rdata, 0);
        next_cycle();
        rst = 1'b1; i_req = 1'b1; i_addr = 14'h010;
        #1;
        chk("mid_normal_i", i_gnt, 1);
        next_cycle();
        i_req = 1'b0;
        #1;
        chk("mid_i_rdata", i_rdata, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
